// File: rtl/persiana_pkg.sv
// Shared definitions for the blind actuator: controller states and the
// position codes exchanged with the blind's Moore FSM.
package persiana_pkg;

    typedef enum logic [2:0] {
        HOMING,
        REPOSO,
        SUBE,
        BAJA,
        PAUSA,
        FALLA
    } estado_t;

    localparam logic [1:0] CERRADA = 2'b00;
    localparam logic [1:0] MEDIA   = 2'b01;
    localparam logic [1:0] ABIERTA = 2'b10;
    localparam logic [1:0] HOLD    = 2'b11;

endpackage

// File: rtl/divisor_tick.sv
// Motor step prescaler: one tick every PRESCALE cycles while enabled, and the
// count restarts from zero whenever enable drops.
module divisor_tick #(
    parameter int PRESCALE = 4
) (
    input  logic reloj,
    input  logic reset,
    input  logic enable,
    output logic tick
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] ULTIMO = CW'(PRESCALE - 1);

    logic [CW-1:0] cuenta;

    always_ff @(posedge reloj or negedge reset) begin
        if (!reset) begin
            cuenta <= '0;
        end else if (!enable || cuenta == ULTIMO) begin
            cuenta <= '0;
        end else begin
            cuenta <= cuenta + CW'(1);
        end
    end

    assign tick = enable && (cuenta == ULTIMO);

endmodule

// File: rtl/persiana_actuador.sv
// Blind motor actuator: homes against the bottom switch, then steps the blind
// to the commanded position with a dead time before every direction reversal.
module persiana_actuador
    import persiana_pkg::*;
#(
    parameter int PRESCALE    = 4,
    parameter int FULL_STEPS  = 8,
    parameter int DEAD_CYCLES = 3
) (
    input  logic       reloj,
    input  logic       reset,
    input  logic [1:0] P,
    input  logic       fin_abajo,
    input  logic       fin_arriba,
    output logic       subir,
    output logic       bajar,
    output logic [1:0] posicion,
    output logic       ocupado,
    output logic       falla
);

    localparam int PW           = $clog2(FULL_STEPS + 1);
    localparam int HOMING_TICKS = FULL_STEPS + FULL_STEPS / 4;
    localparam int TW           = $clog2(HOMING_TICKS + 1);
    localparam int DW           = $clog2(DEAD_CYCLES + 1);

    localparam logic [PW-1:0] POS_MAX      = PW'(FULL_STEPS);
    localparam logic [PW-1:0] POS_MED      = PW'(FULL_STEPS / 2);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(HOMING_TICKS - 1);
    localparam logic [DW-1:0] PAUSA_LAST   = DW'(DEAD_CYCLES - 1);

    estado_t       estado;
    logic [PW-1:0] pos;
    logic [PW-1:0] posTick;
    logic [PW-1:0] objetivo;
    logic [TW-1:0] cuentaTimeout;
    logic [DW-1:0] cuentaPausa;
    logic          tick;
    logic          enMovimiento;

    assign enMovimiento = (estado == HOMING) || (estado == SUBE) || (estado == BAJA);

    divisor_tick #(
        .PRESCALE(PRESCALE)
    ) uDivisor (
        .reloj  (reloj),
        .reset  (reset),
        .enable (enMovimiento),
        .tick   (tick)
    );

    // A landing tick is folded into the position before any target comparison.
    always_comb begin
        posTick = pos;
        if (tick && estado == SUBE && pos != POS_MAX) begin
            posTick = pos + PW'(1);
        end else if (tick && estado == BAJA && pos != '0) begin
            posTick = pos - PW'(1);
        end

        case (P)
            CERRADA: objetivo = '0;
            MEDIA:   objetivo = POS_MED;
            ABIERTA: objetivo = POS_MAX;
            default: objetivo = posTick;
        endcase
    end

    always_ff @(posedge reloj or negedge reset) begin
        if (!reset) begin
            estado        <= HOMING;
            pos           <= '0;
            cuentaTimeout <= '0;
            cuentaPausa   <= '0;
            subir         <= 1'b0;
            bajar         <= 1'b0;
            falla         <= 1'b0;
        end else begin
            subir <= 1'b0;
            bajar <= 1'b0;
            if (estado != FALLA && fin_abajo && fin_arriba) begin
                estado <= FALLA;
                falla  <= 1'b1;
            end else begin
                case (estado)
                    HOMING: begin
                        if (fin_abajo) begin
                            pos           <= '0;
                            cuentaTimeout <= '0;
                            estado        <= REPOSO;
                        end else if (tick && cuentaTimeout == TIMEOUT_LAST) begin
                            estado <= FALLA;
                            falla  <= 1'b1;
                        end else begin
                            bajar <= 1'b1;
                            if (tick) begin
                                cuentaTimeout <= cuentaTimeout + TW'(1);
                            end
                        end
                    end
                    REPOSO: begin
                        if (objetivo > pos) begin
                            estado <= SUBE;
                            subir  <= 1'b1;
                        end else if (objetivo < pos) begin
                            estado <= BAJA;
                            bajar  <= 1'b1;
                        end
                    end
                    SUBE: begin
                        pos <= posTick;
                        if (fin_arriba) begin
                            pos    <= POS_MAX;
                            estado <= REPOSO;
                        end else if (P == HOLD || posTick == objetivo) begin
                            estado <= REPOSO;
                        end else if (objetivo < posTick) begin
                            estado      <= PAUSA;
                            cuentaPausa <= '0;
                        end else begin
                            subir <= 1'b1;
                        end
                    end
                    BAJA: begin
                        pos <= posTick;
                        if (fin_abajo) begin
                            pos    <= '0;
                            estado <= REPOSO;
                        end else if (P == HOLD || posTick == objetivo) begin
                            estado <= REPOSO;
                        end else if (objetivo > posTick) begin
                            estado      <= PAUSA;
                            cuentaPausa <= '0;
                        end else begin
                            bajar <= 1'b1;
                        end
                    end
                    PAUSA: begin
                        if (cuentaPausa == PAUSA_LAST) begin
                            cuentaPausa <= '0;
                            if (objetivo > pos) begin
                                estado <= SUBE;
                                subir  <= 1'b1;
                            end else if (objetivo < pos) begin
                                estado <= BAJA;
                                bajar  <= 1'b1;
                            end else begin
                                estado <= REPOSO;
                            end
                        end else begin
                            cuentaPausa <= cuentaPausa + DW'(1);
                        end
                    end
                    FALLA: begin
                        falla <= 1'b1;
                    end
                    default: begin
                        estado <= FALLA;
                        falla  <= 1'b1;
                    end
                endcase
            end
        end
    end

    // Position is only meaningful once homed; anything off the three stops reads HOLD.
    always_comb begin
        if (estado == HOMING) begin
            posicion = HOLD;
        end else if (pos == '0) begin
            posicion = CERRADA;
        end else if (pos == POS_MED) begin
            posicion = MEDIA;
        end else if (pos == POS_MAX) begin
            posicion = ABIERTA;
        end else begin
            posicion = HOLD;
        end
    end

    assign ocupado = (estado != REPOSO);

endmodule

// File: tb/tb_persiana_actuador.sv
// Directed self-checking bench for persiana_actuador with PRESCALE=4,
// FULL_STEPS=8, DEAD_CYCLES=3.
module tb_persiana_actuador;
    import persiana_pkg::*;

    logic       reloj = 1'b0;
    logic       reset;
    logic [1:0] P;
    logic       fin_abajo;
    logic       fin_arriba;
    logic       subir;
    logic       bajar;
    logic [1:0] posicion;
    logic       ocupado;
    logic       falla;

    int asserts;
    int fails;
    int n;

    persiana_actuador #(
        .PRESCALE(4),
        .FULL_STEPS(8),
        .DEAD_CYCLES(3)
    ) dut (
        .reloj      (reloj),
        .reset      (reset),
        .P          (P),
        .fin_abajo  (fin_abajo),
        .fin_arriba (fin_arriba),
        .subir      (subir),
        .bajar      (bajar),
        .posicion   (posicion),
        .ocupado    (ocupado),
        .falla      (falla)
    );

    always #5 reloj = ~reloj;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: time limit reached before end of test");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        asserts++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] p, input logic abajo, input logic arriba);
        P          = p;
        fin_abajo  = abajo;
        fin_arriba = arriba;
    endtask

    // Counts consecutive motor-on cycles starting at the very next sample.
    task automatic measureMotor(input bit up, input int expected, input string tag);
        int cnt;
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge reloj);
            if ((up ? subir : bajar) === 1'b1) cnt++;
            else break;
        end
        checkOutput(tag, cnt, expected);
    endtask

    initial begin
        asserts = 0;
        fails   = 0;
        reset   = 1'b0;
        applyStimulus(HOLD, 1'b0, 1'b0);
        repeat (3) @(negedge reloj);
        checkOutput("reset subir", subir, 0);
        checkOutput("reset bajar", bajar, 0);
        checkOutput("reset falla", falla, 0);
        checkOutput("reset posicion", posicion, 3);
        checkOutput("reset ocupado", ocupado, 1);

        reset = 1'b1;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge reloj);
            if (bajar === 1'b1) n++;
        end
        checkOutput("homing bajar cycles", n, 10);
        checkOutput("homing posicion", posicion, 3);
        applyStimulus(HOLD, 1'b1, 1'b0);
        @(negedge reloj);
        checkOutput("homed bajar", bajar, 0);
        checkOutput("homed posicion", posicion, 0);
        checkOutput("homed ocupado", ocupado, 0);

        applyStimulus(ABIERTA, 1'b0, 1'b0);
        measureMotor(1'b1, 32, "subir cycles 0->8");
        checkOutput("open posicion", posicion, 2);
        checkOutput("open ocupado", ocupado, 0);
        checkOutput("open bajar", bajar, 0);

        applyStimulus(MEDIA, 1'b0, 1'b0);
        measureMotor(1'b0, 16, "bajar cycles 8->4");
        checkOutput("half posicion", posicion, 1);

        applyStimulus(CERRADA, 1'b0, 1'b0);
        repeat (6) @(negedge reloj);
        checkOutput("midmove bajar", bajar, 1);
        checkOutput("midmove posicion", posicion, 3);
        applyStimulus(HOLD, 1'b0, 1'b0);
        @(negedge reloj);
        checkOutput("hold bajar", bajar, 0);
        checkOutput("hold posicion", posicion, 3);
        checkOutput("hold ocupado", ocupado, 0);

        applyStimulus(ABIERTA, 1'b0, 1'b0);
        @(negedge reloj);
        checkOutput("reverse start subir", subir, 1);
        applyStimulus(CERRADA, 1'b0, 1'b0);
        n = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge reloj);
            if (subir === 1'b0 && bajar === 1'b0 && ocupado === 1'b1) n++;
        end
        checkOutput("dead cycles", n, 3);
        measureMotor(1'b0, 12, "bajar cycles 3->0");
        checkOutput("closed posicion", posicion, 0);

        applyStimulus(ABIERTA, 1'b0, 1'b0);
        repeat (21) @(negedge reloj);
        checkOutput("pos5 subir", subir, 1);
        checkOutput("pos5 posicion", posicion, 3);
        applyStimulus(ABIERTA, 1'b0, 1'b1);
        @(negedge reloj);
        checkOutput("top switch subir", subir, 0);
        checkOutput("top switch posicion", posicion, 2);
        checkOutput("top switch ocupado", ocupado, 0);
        applyStimulus(ABIERTA, 1'b0, 1'b0);
        repeat (3) @(negedge reloj);
        checkOutput("at target ocupado", ocupado, 0);
        checkOutput("at target subir", subir, 0);

        applyStimulus(ABIERTA, 1'b1, 1'b1);
        @(negedge reloj);
        checkOutput("both switches falla", falla, 1);
        checkOutput("both switches ocupado", ocupado, 1);
        checkOutput("both switches subir", subir, 0);
        checkOutput("both switches bajar", bajar, 0);
        applyStimulus(CERRADA, 1'b0, 1'b0);
        repeat (5) @(negedge reloj);
        checkOutput("falla sticky", falla, 1);
        checkOutput("falla bajar", bajar, 0);
        reset = 1'b0;
        #1;
        checkOutput("async reset falla", falla, 0);
        checkOutput("async reset posicion", posicion, 3);
        checkOutput("async reset ocupado", ocupado, 1);

        @(negedge reloj);
        reset = 1'b1;
        n = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge reloj);
            n++;
            if (i == 0) checkOutput("timeout homing bajar", bajar, 1);
            if (falla === 1'b1) break;
        end
        checkOutput("homing timeout cycles", n, 40);
        checkOutput("timeout bajar off", bajar, 0);

        reset = 1'b0;
        @(negedge reloj);
        reset = 1'b1;
        repeat (2) @(negedge reloj);
        applyStimulus(CERRADA, 1'b1, 1'b0);
        @(negedge reloj);
        applyStimulus(CERRADA, 1'b0, 1'b0);
        checkOutput("rehomed ocupado", ocupado, 0);
        applyStimulus(ABIERTA, 1'b0, 1'b0);
        repeat (5) @(negedge reloj);
        checkOutput("moving subir", subir, 1);
        reset = 1'b0;
        #1;
        checkOutput("reset midmove subir", subir, 0);
        checkOutput("reset midmove bajar", bajar, 0);
        checkOutput("reset midmove ocupado", ocupado, 1);
        @(negedge reloj);
        reset = 1'b1;
        @(negedge reloj);
        checkOutput("restart homing bajar", bajar, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule

// File: doc/persiana_actuador.md
PERSIANA_ACTUADOR -- requirements
Module: persiana_actuador

Interface
REQ-001 Parameter PRESCALE, default 4: clock cycles per motor step tick.
REQ-002 Parameter FULL_STEPS, default 8, even, >=4: step count from fully closed (0) to fully open.
REQ-003 Parameter DEAD_CYCLES, default 3, >=1: motor-off cycles required before any direction reversal.
REQ-004 reloj  input  1  single clock, rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 P  input  2  commanded position from the blind Moore FSM: 00 cerrada, 01 media, 10 abierta, 11 hold.
REQ-007 fin_abajo  input  1  bottom limit switch, active-high, synchronous to reloj.
REQ-008 fin_arriba  input  1  top limit switch, active-high, synchronous to reloj.
REQ-009 subir  output  1  motor up drive, registered.
REQ-010 bajar  output  1  motor down drive, registered.
REQ-011 posicion  output  2  reached position: 00 at step 0, 01 at step FULL_STEPS/2, 10 at FULL_STEPS, 11 anywhere else or while homing.
REQ-012 ocupado  output  1  high whenever state is not REPOSO.
REQ-013 falla  output  1  high in state FALLA.

Function
REQ-014 States SHALL be HOMING, REPOSO, SUBE, BAJA, PAUSA, FALLA.
REQ-015 Target SHALL be 0, FULL_STEPS/2 or FULL_STEPS for P = 00, 01 or 10; P=11 SHALL set target = current position.
REQ-016 subir=1 only in SUBE, bajar=1 only in HOMING and BAJA; both high together SHALL never occur.
REQ-017 A step counter (prescaler) SHALL restart at 0 on every entry to SUBE, BAJA or HOMING and emit one tick every PRESCALE cycles while in them.
REQ-018 Each tick in SUBE SHALL increment pos, each tick in BAJA SHALL decrement pos; pos saturates at 0 and FULL_STEPS.
REQ-019 HOMING: drive down until fin_abajo=1, then pos=0 and go to REPOSO next cycle.
REQ-020 HOMING timeout: if FULL_STEPS + FULL_STEPS/4 ticks elapse without fin_abajo, go to FALLA.
REQ-021 REPOSO: target > pos -> SUBE next cycle; target < pos -> BAJA next cycle; equal -> stay.
REQ-022 SUBE/BAJA: when pos equals target, go to REPOSO in the same cycle the tick lands (subir/bajar low on the next edge).
REQ-023 SUBE with target < pos, or BAJA with target > pos: go to PAUSA, hold DEAD_CYCLES cycles with motor off, then enter the new direction; target re-evaluated at PAUSA exit, equal -> REPOSO.
REQ-024 SUBE or BAJA with P=11: go to REPOSO immediately, pos kept.
REQ-025 fin_arriba=1 in SUBE: pos=FULL_STEPS, go to REPOSO; fin_abajo=1 in BAJA: pos=0, go to REPOSO (limit switch wins over tick count).
REQ-026 fin_arriba and fin_abajo both 1 in any state except FALLA: go to FALLA.
REQ-027 FALLA: motor outputs low, ocupado=1, falla=1; exit only by reset.
REQ-028 Simultaneous tick and P change: tick applied first, then transition rules evaluated against new pos.

Reset
REQ-029 reset=0 SHALL asynchronously force state=HOMING, pos=0, prescaler=0, timeout=0, subir=0, bajar=0, falla=0.
REQ-030 During reset, posicion=11 and ocupado=1; first edge after reset release starts HOMING with bajar=1.
REQ-031 Reset mid-motion SHALL drop the motor outputs within the same cycle (asynchronously), no PAUSA required.

Structure
REQ-032 Package persiana_pkg SHALL hold the state enumeration and the P/posicion codes (CERRADA, MEDIA, ABIERTA, HOLD) shared with the Moore FSM.
REQ-033 Prescaler SHALL be sub-module divisor_tick (inputs reloj, reset, enable; output tick).

Verification (PRESCALE=4, FULL_STEPS=8, DEAD_CYCLES=3)
REQ-034 Reset release, fin_abajo raised after 10 cycles -> bajar=1 for 10 cycles, then REPOSO, posicion=00, ocupado=0.
REQ-035 From REPOSO pos=0, P=10 -> subir=1 for 32 cycles, pos=8, posicion=10, subir=0.
REQ-036 From pos=8, P=01 -> bajar for 16 cycles, posicion=01; then P=11 mid-motion -> motor off next cycle, posicion=11.
REQ-037 SUBE at pos=3, P changed to 00 -> subir=0, 3 cycles both low, then bajar=1 until pos=0.
REQ-038 SUBE at pos=5, fin_arriba=1 -> pos=8, REPOSO, posicion=10.
REQ-039 fin_abajo=fin_arriba=1 in REPOSO -> falla=1 next cycle, stays until reset=0; HOMING with no fin_abajo -> falla=1 after 40 cycles.
